// File: rtl/datamem_dump_sequencer_pkg.sv
// Shared types and defaults for the data-memory dump sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The debug unit decodes the state encoding below for status readback.
// Keep these values stable.
package datamem_dump_sequencer_pkg;

    // Default widths: data word, debug word address (port-B word index), transfer count.
    localparam int NB_REG_DEF   = 32;
    localparam int NB_ADDR_DEF  = 16;
    localparam int NB_COUNT_DEF = 16;

    // FSM encoding exported for status readback.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_HOLD      = 2'd3
    } dump_state_t;

    // Busy means any state other than IDLE.
    function automatic logic state_is_busy(input dump_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/datamem_dump_sequencer.sv
// Streams a block of data-memory words from the debug read port (port B) out
// through a valid/ready handshake.
// Latency: start -> read issued in cycle 1 -> first o_data_valid in cycle 3;
//          one word in flight, so throughput is 1 word per 3 cycles.
// Backpressure: o_data is held in HOLD until i_data_ready; no new read is
//          issued until the held word is taken.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_start/i_base_addr/    start request with first word address and word count,
//   i_count                 sampled only in IDLE
//   i_abort                 cancel; FSM is back in IDLE the next cycle
//   o_datamem_addr/_re      debug-port address and read enable
//   i_datamem_data          debug-port read data, valid 1 cycle after o_datamem_re
//   o_data/_valid, i_data_ready   output word stream
//   o_busy                  state != IDLE
//   o_done                  1-cycle pulse in the first IDLE cycle after a normal finish
module datamem_dump_sequencer
    import datamem_dump_sequencer_pkg::*;
#(
    parameter int NB_REG   = NB_REG_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int NB_COUNT = NB_COUNT_DEF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_ADDR-1:0]  i_base_addr,
    input  logic [NB_COUNT-1:0] i_count,
    input  logic                i_abort,
    output logic [NB_ADDR-1:0]  o_datamem_addr,
    output logic                o_datamem_re,
    input  logic [NB_REG-1:0]   i_datamem_data,
    output logic [NB_REG-1:0]   o_data,
    output logic                o_data_valid,
    input  logic                i_data_ready,
    output logic                o_busy,
    output logic                o_done
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dump_state_t         state_q, state_d;
    logic [NB_ADDR-1:0]  addr_q,  addr_d;   // word address of the current read
    logic [NB_COUNT-1:0] rem_q,   rem_d;    // words still to hand over
    logic [NB_REG-1:0]   data_q,  data_d;   // output word register
    logic                done_q,  done_d;

    logic xfer;       // handshake on the held word
    logic last_word;  // the held word is the final one of the block

    assign xfer      = (state_q == ST_HOLD) && i_data_ready;
    assign last_word = (rem_q == NB_COUNT'(1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        addr_d  = i_base_addr;
                        rem_d   = i_count;
                        state_d = ST_ISSUE;
                    end else begin
                        // Empty block: report completion without touching memory.
                        done_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                // Read enable is decoded from this state.
                state_d = ST_WAIT_DATA;
            end

            ST_WAIT_DATA: begin
                // Registered RAM returns data this cycle; capture it.
                data_d  = i_datamem_data;
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (xfer) begin
                    rem_d  = rem_q - NB_COUNT'(1);
                    // Wraps silently at the top of the address space.
                    addr_d = addr_q + NB_ADDR'(1);
                    if (last_word) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition. A handshake in the same cycle still
        // consumes the word (counters above already advanced), but the block is
        // not reported as done; a start in IDLE is dropped.
        if (i_abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            if (state_q == ST_IDLE) begin
                addr_d = addr_q;
                rem_d  = rem_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registers or pure state decodes, no input-to-output paths
    // ------------------------------------------------------------------
    assign o_datamem_addr = addr_q;
    assign o_datamem_re   = (state_q == ST_ISSUE);
    assign o_data         = data_q;
    assign o_data_valid   = (state_q == ST_HOLD);
    assign o_busy         = state_is_busy(state_q);
    assign o_done         = done_q;

endmodule

// File: tb/tb_datamem_dump_sequencer.sv
// Directed bench for the data-memory dump sequencer with a scoreboard of
// expected read addresses and streamed words.
module tb_datamem_dump_sequencer;

    localparam int NB_REG   = 32;
    localparam int NB_ADDR  = 16;
    localparam int NB_COUNT = 16;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                i_start;
    logic [NB_ADDR-1:0]  i_base_addr;
    logic [NB_COUNT-1:0] i_count;
    logic                i_abort;
    logic [NB_ADDR-1:0]  o_datamem_addr;
    logic                o_datamem_re;
    logic [NB_REG-1:0]   i_datamem_data;
    logic [NB_REG-1:0]   o_data;
    logic                o_data_valid;
    logic                i_data_ready;
    logic                o_busy;
    logic                o_done;

    always #5 clk = ~clk;

    datamem_dump_sequencer #(
        .NB_REG   (NB_REG),
        .NB_ADDR  (NB_ADDR),
        .NB_COUNT (NB_COUNT)
    ) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_count        (i_count),
        .i_abort        (i_abort),
        .o_datamem_addr (o_datamem_addr),
        .o_datamem_re   (o_datamem_re),
        .i_datamem_data (i_datamem_data),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .i_data_ready   (i_data_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Debug port: registered RAM with mem[i] = A500_0000 + i.
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return 32'hA500_0000 + {16'h0000, a};
    endfunction

    always @(posedge clk) begin
        if (o_datamem_re) i_datamem_data <= ram_word(o_datamem_addr);
    end

    // Scoreboard and counters.
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    logic mon_en = 1'b0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_datamem_re) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
                else chk("read_addr", 64'(o_datamem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (o_data_valid && i_data_ready) begin
                xfer_cnt++;
                if (exp_data_q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
                else chk("stream_word", 64'(o_data), 64'(exp_data_q.pop_front()));
            end
            if (o_data_valid && prev_hold) chk("hold_stable", 64'(o_data), 64'(prev_data));
            prev_hold = o_data_valid && !i_data_ready;
            prev_data = o_data;
            if (o_done) begin
                done_cnt++;
                chk("done_excl_busy", 64'(o_busy), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle and push the expected reads/words.
    // Returns one cycle after the start was sampled.
    task automatic start_xfer(input logic [15:0] base, input logic [15:0] cnt, input logic expect_run);
        logic [15:0] a;
        if (expect_run) begin
            for (int i = 0; i < int'(cnt); i++) begin
                a = base + 16'(i);
                exp_addr_q.push_back(a);
                exp_data_q.push_back(ram_word(a));
            end
        end
        i_start     = 1'b1;
        i_base_addr = base;
        i_count     = cnt;
        step();
        i_start = 1'b0;
    endtask

    // Returns at the falling edge where o_data_valid is seen, or flags a timeout.
    task automatic wait_valid(input string tag, input int budget);
        logic seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (o_data_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 64'(seen), 64'd1);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] re_m, vld_m, done_m, busy_m;
        logic [31:0] d0;
        logic        stable;
        int          d_before, x_before;

        i_reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_count = '0;
        i_abort = 1'b0; i_data_ready = 1'b0;
        repeat (3) step();
        i_reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {12'h0, o_data, o_datamem_addr, o_datamem_re, o_data_valid, o_busy, o_done}, 64'd0);
        mon_en = 1'b1;
        step();

        // 1: four words, ready always high; exact cycle pattern.
        i_data_ready = 1'b1;
        d_before = done_cnt;
        re_m = '0; vld_m = '0; done_m = '0; busy_m = '0;
        start_xfer(16'h0010, 16'd4, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            re_m[k] = o_datamem_re; vld_m[k] = o_data_valid;
            done_m[k] = o_done;     busy_m[k] = o_busy;
            step();
        end
        chk("t1_re_cycles",    64'(re_m),   64'h0492);
        chk("t1_valid_cycles", 64'(vld_m),  64'h1248);
        chk("t1_done_cycles",  64'(done_m), 64'h2000);
        chk("t1_busy_cycles",  64'(busy_m), 64'h1FFE);
        chk("t1_drained", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);

        // 2: backpressure, ready low for 5 cycles in each HOLD.
        i_data_ready = 1'b0;
        d_before = done_cnt; x_before = xfer_cnt;
        start_xfer(16'd5, 16'd3, 1'b1);
        for (int w = 0; w < 3; w++) begin
            wait_valid("t2_valid", 12);
            d0 = o_data;
            stable = 1'b1;
            repeat (4) begin
                step();
                @(negedge clk);
                if (!o_data_valid || o_data !== d0) stable = 1'b0;
            end
            chk("t2_stable", 64'(stable), 64'd1);
            step();
            i_data_ready = 1'b1;
            step();
            i_data_ready = 1'b0;
        end
        repeat (4) step();
        chk("t2_xfers", 64'(xfer_cnt - x_before), 64'd3);
        chk("t2_single_done", 64'(done_cnt - d_before), 64'd1);
        chk("t2_drained", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);

        // 3: zero-length block.
        i_data_ready = 1'b1;
        done_m = '0; busy_m = '0; re_m = '0;
        start_xfer(16'h0033, 16'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            done_m[k] = o_done; busy_m[k] = o_busy; re_m[k] = o_datamem_re;
            step();
        end
        chk("t3_done_cycles", 64'(done_m), 64'h0002);
        chk("t3_busy",        64'(busy_m), 64'h0000);
        chk("t3_no_read",     64'(re_m),   64'h0000);

        // 4: address wrap.
        d_before = done_cnt;
        start_xfer(16'hFFFE, 16'd3, 1'b1);
        wait_done("t4_done", 20);
        chk("t4_drained", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);
        chk("t4_done_count", 64'(done_cnt - d_before), 64'd1);

        // 5: abort in WAIT_DATA of word 2 of 8.
        d_before = done_cnt;
        start_xfer(16'h0100, 16'd8, 1'b1);
        repeat (4) step();
        i_abort = 1'b1;
        @(negedge clk);
        chk("t5_in_wait", {61'h0, o_busy, o_data_valid, o_datamem_re}, 64'h4);
        step();
        i_abort = 1'b0;
        @(negedge clk);
        chk("t5_after_abort", {60'h0, o_busy, o_data_valid, o_datamem_re, o_done}, 64'h0);
        chk("t5_words_left", 64'(exp_data_q.size()), 64'd7);
        chk("t5_reads_left", 64'(exp_addr_q.size()), 64'd6);
        exp_data_q.delete();
        exp_addr_q.delete();
        repeat (3) step();
        chk("t5_no_done", 64'(done_cnt - d_before), 64'd0);
        // Abort together with start in IDLE: start dropped.
        i_abort = 1'b1;
        start_xfer(16'h0200, 16'd2, 1'b0);
        i_abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_start", {62'h0, o_busy, o_done}, 64'h0);
        step();
        start_xfer(16'h0000, 16'd1, 1'b1);
        wait_done("t5_restart_done", 12);
        chk("t5_restart_drained", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);

        // 6a: start while busy is ignored.
        i_data_ready = 1'b0;
        start_xfer(16'h0020, 16'd4, 1'b1);
        step();
        i_start = 1'b1; i_base_addr = 16'h0300; i_count = 16'd9;
        step();
        i_start = 1'b0;
        i_data_ready = 1'b1;
        wait_done("t6_done", 40);
        chk("t6_drained", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);
        repeat (3) step();
        chk("t6_idle", 64'(o_busy), 64'd0);

        // 6b: reset while holding a word.
        i_data_ready = 1'b0;
        d_before = done_cnt;
        start_xfer(16'h0040, 16'd3, 1'b1);
        wait_valid("t6_hold", 12);
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", {12'h0, o_data, o_datamem_addr, o_datamem_re, o_data_valid, o_busy, o_done}, 64'd0);
        chk("t6_words_left", 64'(exp_data_q.size()), 64'd3);
        chk("t6_reads_left", 64'(exp_addr_q.size()), 64'd2);
        exp_data_q.delete();
        exp_addr_q.delete();
        repeat (4) step();
        chk("t6_no_done", 64'(done_cnt - d_before), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
